// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared fixed-point configuration and Sobol generator types
//
// Purpose: project-wide fixed-point format constants, plus the types used by
//          the Sobol point generator (direction-number word, FSM state).
// Ports:   none (package).
package fpga_cfg_pkg;

  localparam int FP_WIDTH        = 32;
  localparam int FP_QFRAC        = 16;
  localparam int SOBOL_DIR_DEPTH = FP_QFRAC;

  typedef logic [FP_QFRAC-1:0] sobol_dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sobol_state_e;

endpackage

// File: rtl/sobol_point_gen_if.sv
// rtl/sobol_point_gen_if.sv - point stream handshake between Sobol generator and folding stage
//
// Purpose: carries one Sobol point per valid/ready handshake.
// Signals:
//   valid_out  generator -> consumer  u/index are valid
//   ready_in   consumer  -> generator consumer can take the point
//   u          generator -> consumer  point in Q(WIDTH-QFRAC).QFRAC, strictly in (0,1)
//   index      generator -> consumer  Sobol index n of u (first point is 1)
// Modports: master (generator side), slave (consumer side).
interface sobol_point_gen_if
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int CNT_W = 32
);

  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] u;
  logic [CNT_W-1:0] index;

  modport master (output valid_out, output u, output index, input ready_in);
  modport slave  (input valid_out, input u, input index, output ready_in);

endinterface

// File: rtl/sobol_ctz.sv
// rtl/sobol_ctz.sv - trailing-zero count priority encoder
//
// Purpose: returns the position of the lowest set bit of value (purely combinational).
// Ports:
//   value  in   CNT_W  word to scan
//   count  out  OUT_W  number of trailing zeros (0 when value is 0)
// The result is truncated to OUT_W bits; callers guarantee it fits.
module sobol_ctz #(
  parameter int CNT_W = 32,
  parameter int OUT_W = 4
) (
  input  logic [CNT_W-1:0] value,
  output logic [OUT_W-1:0] count
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    count = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (value[i]) count = OUT_W'(i);
    end
  end

endmodule

// File: rtl/sobol_point_gen.sv
// rtl/sobol_point_gen.sv - single-dimension Gray-code Sobol point generator
//
// Purpose: emits n_points Sobol points u (index 1..n_eff) in Q(WIDTH-QFRAC).QFRAC,
//          one per handshake, using the Antonov-Saleev recurrence
//          x(n+1) = x(n) ^ v[ctz(n+1)]. Index 0 (u = 0) is never emitted.
// Optional feature macro: SOBOL_DIGITAL_SHIFT_EN (digital shift by shift_seed).
// Ports:
//   clk         in   1       clock
//   rst_n       in   1       synchronous active-low reset
//   start       in   1       begin a run (sampled in IDLE only)
//   n_points    in   CNT_W   number of points, clamped to 2^QFRAC-1
//   dir_we      in   1       direction-number write strobe (IDLE only)
//   dir_addr    in   log2(QFRAC) direction-number index k
//   dir_data    in   QFRAC   direction number v[k], Q0.QFRAC
//   shift_seed  in   QFRAC   digital-shift seed (only with SOBOL_DIGITAL_SHIFT_EN)
//   pt          master      point stream: valid_out, ready_in, u, index
//   busy        out  1       high while in RUN
//   done        out  1       one-cycle pulse when a run completes
module sobol_point_gen
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         n_points,
  input  logic                     dir_we,
  input  logic [$clog2(QFRAC)-1:0] dir_addr,
  input  logic [QFRAC-1:0]         dir_data,
`ifdef SOBOL_DIGITAL_SHIFT_EN
  input  logic [QFRAC-1:0]         shift_seed,
`endif
  sobol_point_gen_if.master        pt,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(QFRAC);
  // Largest index whose Gray step still has a direction number.
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'((64'd1 << QFRAC) - 64'd1);

  sobol_state_e     state_q, state_n;
  logic [QFRAC-1:0] v_q [QFRAC];
  logic [QFRAC-1:0] x_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] neff_q;
  logic             valid_q;
  logic [WIDTH-1:0] u_q;

  logic [CNT_W-1:0] n_eff;
  logic [AW-1:0]    step_k;
  logic [QFRAC-1:0] x_nxt;
  logic             load, adv, last;
  logic [WIDTH-1:0] u_load, u_adv;

  // ---------------------------------------------------------------------
  // Output shaping: optional digital shift with the zero point remapped
  // to 1 LSB so the downstream stage never sees u = 0.
  // ---------------------------------------------------------------------
`ifdef SOBOL_DIGITAL_SHIFT_EN
  logic [QFRAC-1:0] seed_q;

  function automatic logic [WIDTH-1:0] shape_u(input logic [QFRAC-1:0] x,
                                               input logic [QFRAC-1:0] s);
    logic [QFRAC-1:0] y;
    y = x ^ s;
    if (y == '0) y = QFRAC'(1);
    return WIDTH'(y);
  endfunction

  always_comb begin
    u_load = shape_u(v_q[0], shift_seed);
    u_adv  = shape_u(x_nxt, seed_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) seed_q <= '0;
    else if (state_q == IDLE && start) seed_q <= shift_seed;
  end
`else
  function automatic logic [WIDTH-1:0] shape_u(input logic [QFRAC-1:0] x);
    return WIDTH'(x);
  endfunction

  always_comb begin
    u_load = shape_u(v_q[0]);
    u_adv  = shape_u(x_nxt);
  end
`endif

  // ---------------------------------------------------------------------
  // Gray-code step
  // ---------------------------------------------------------------------
  assign n_eff = (n_points > MAX_N) ? MAX_N : n_points;

  sobol_ctz #(
    .CNT_W (CNT_W),
    .OUT_W (AW)
  ) u_ctz (
    .value (n_q + CNT_W'(1)),
    .count (step_k)
  );

  assign x_nxt = x_q ^ v_q[step_k];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_eff != '0) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            state_n = FIN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (valid_q && pt.ready_in) begin
          if (n_q == neff_q) begin
            last    = 1'b1;
            state_n = FIN;
          end else begin
            adv = 1'b1;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Point datapath; u/index only change on load or accepted handshake,
  // so they hold while the consumer stalls.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      n_q     <= '0;
      neff_q  <= '0;
      x_q     <= '0;
      u_q     <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      n_q     <= CNT_W'(1);
      neff_q  <= n_eff;
      x_q     <= v_q[0];
      u_q     <= u_load;
    end else if (adv) begin
      n_q <= n_q + CNT_W'(1);
      x_q <= x_nxt;
      u_q <= u_adv;
    end else if (last) begin
      valid_q <= 1'b0;
    end
  end

  // Direction table: writes only in IDLE; a write coincident with start
  // lands after the run has already captured the old v[0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < QFRAC; k++) v_q[k] <= QFRAC'(1) << (QFRAC - 1 - k);
    end else if (state_q == IDLE && dir_we && (32'(dir_addr) < QFRAC)) begin
      v_q[dir_addr] <= dir_data;
    end
  end

  assign pt.valid_out = valid_q;
  assign pt.u         = u_q;
  assign pt.index     = n_q;

endmodule

// File: tb/tb_sobol_point_gen.sv
// tb/tb_sobol_point_gen.sv - self-checking bench for sobol_point_gen
module tb_sobol_point_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] n_points;
  logic        dir_we;
  logic [3:0]  dir_addr;
  logic [15:0] dir_data;
  logic        busy;
  logic        done;
`ifdef SOBOL_DIGITAL_SHIFT_EN
  logic [15:0] shift_seed;
  logic [15:0] seed_m;
`endif

  sobol_point_gen_if #(.WIDTH(32), .CNT_W(32)) pt ();

  sobol_point_gen #(.WIDTH(32), .QFRAC(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_points (n_points),
    .dir_we   (dir_we),
    .dir_addr (dir_addr),
    .dir_data (dir_data),
`ifdef SOBOL_DIGITAL_SHIFT_EN
    .shift_seed (shift_seed),
`endif
    .pt       (pt.master),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mv [16];
  bit          seen [65536];

  // Sobol point n directly from its Gray code: XOR of v[k] over set bits of n^(n>>1).
  function automatic logic [31:0] model_u(input int n);
    logic [31:0] g;
    logic [15:0] x;
    g = 32'(n) ^ (32'(n) >> 1);
    x = '0;
    for (int k = 0; k < 16; k++) if (g[k]) x ^= mv[k];
`ifdef SOBOL_DIGITAL_SHIFT_EN
    x ^= seed_m;
    if (x == 16'h0) x = 16'h1;
`endif
    return {16'h0, x};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic default_model();
    for (int k = 0; k < 16; k++) mv[k] = 16'h8000 >> k;
  endtask

  task automatic write_dir(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    dir_we = 1'b1; dir_addr = a; dir_data = d;
    @(posedge clk); #1;
    dir_we = 1'b0;
    mv[a] = d;
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run(input string tag, input logic [31:0] np, input int mode,
                     input int poke_cyc, input bit wr_start, input logic [15:0] wr_val,
                     input int exp_cnt, input bit distinct);
    int          got, last_hs, done_cyc;
    logic        pv, pr;
    logic [31:0] pu, pidx;
    @(posedge clk); #1;
    start = 1'b1; n_points = np;
`ifdef SOBOL_DIGITAL_SHIFT_EN
    shift_seed = seed_m;
`endif
    if (wr_start) begin dir_we = 1'b1; dir_addr = 4'd0; dir_data = wr_val; end
    @(posedge clk); #1;
    start = 1'b0; dir_we = 1'b0;
    got = 0; last_hs = -1; done_cyc = -1;
    pv = 1'b0; pr = 1'b0; pu = '0; pidx = '0;
    if (distinct) for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
    for (int cyc = 0; cyc < 70000 && done_cyc < 0; cyc++) begin
      case (mode)
        0:       pt.ready_in = 1'b1;
        1:       pt.ready_in = (cyc % 3 == 0);
        default: pt.ready_in = 1'($urandom_range(0, 1));
      endcase
      if (cyc == poke_cyc) begin
        dir_we = 1'b1; dir_addr = 4'd0; dir_data = 16'h1234;
      end else begin
        dir_we = 1'b0;
      end
      @(negedge clk);
      if (pv && !pr) begin
        check({tag, " hold_valid"}, 64'(pt.valid_out), 64'd1);
        check({tag, " hold_u"}, 64'(pt.u), 64'(pu));
        check({tag, " hold_index"}, 64'(pt.index), 64'(pidx));
      end
      if (pt.valid_out && pt.ready_in) begin
        got++;
        check({tag, " index"}, 64'(pt.index), 64'(got));
        check({tag, " u"}, 64'(pt.u), 64'(model_u(got)));
        if (distinct) begin
          check({tag, " u_nonzero"}, 64'(pt.u != 32'h0), 64'd1);
          check({tag, " u_unique"}, 64'(seen[pt.u[15:0]]), 64'd0);
          seen[pt.u[15:0]] = 1'b1;
        end
        last_hs = cyc;
      end
      if (done) done_cyc = cyc;
      pv = pt.valid_out; pr = pt.ready_in; pu = pt.u; pidx = pt.index;
      @(posedge clk); #1;
    end
    dir_we = 1'b0;
    check({tag, " count"}, 64'(got), 64'(exp_cnt));
    check({tag, " done_cycle"}, 64'(done_cyc), (exp_cnt == 0) ? 64'd0 : 64'(last_hs + 1));
    @(negedge clk);
    check({tag, " done_width"}, 64'(done), 64'd0);
    check({tag, " busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_points = '0;
    dir_we = 1'b0; dir_addr = '0; dir_data = '0;
    pt.ready_in = 1'b0;
`ifdef SOBOL_DIGITAL_SHIFT_EN
    shift_seed = '0; seed_m = '0;
`endif
    default_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst valid_out", 64'(pt.valid_out), 64'd0);
    check("rst u", 64'(pt.u), 64'd0);
    check("rst index", 64'(pt.index), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run("basic4", 32'd4, 0, -1, 1'b0, 16'h0, 4, 1'b0);
    run("toggle4", 32'd4, 1, -1, 1'b0, 16'h0, 4, 1'b0);
    run("zero", 32'd0, 0, -1, 1'b0, 16'h0, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int np;
      np = int'($urandom_range(1, 40));
`ifdef SOBOL_DIGITAL_SHIFT_EN
      seed_m = 16'($urandom);
`endif
      run("rand_def", 32'(np), 2, -1, 1'b0, 16'h0, np, 1'b0);
    end
`ifdef SOBOL_DIGITAL_SHIFT_EN
    seed_m = '0;
`endif

    // Custom table; a write during RUN must not disturb it.
    write_dir(4'd0, 16'h8000);
    write_dir(4'd1, 16'hC000);
    run("custom3", 32'd3, 0, 1, 1'b0, 16'h0, 3, 1'b0);
    run("after_poke", 32'd1, 0, -1, 1'b0, 16'h0, 1, 1'b0);

    // Write coincident with start: first point uses the old v[0].
    run("collide", 32'd1, 0, -1, 1'b1, 16'h2000, 1, 1'b0);
    mv[0] = 16'h2000;
    run("post_collide", 32'd3, 0, -1, 1'b0, 16'h0, 3, 1'b0);

    // Random table, random back-pressure.
    for (int k = 0; k < 16; k++) write_dir(4'(k), 16'($urandom));
    for (int r = 0; r < 3; r++) begin
      int np;
      np = int'($urandom_range(1, 60));
      run("rand_tab", 32'(np), 2, -1, 1'b0, 16'h0, np, 1'b0);
    end

    // Reset mid-run aborts and restores the default table.
    @(posedge clk); #1;
    start = 1'b1; n_points = 32'd10; pt.ready_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst valid_out", 64'(pt.valid_out), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst index", 64'(pt.index), 64'd0);
    default_model();
    run("post_rst", 32'd5, 2, -1, 1'b0, 16'h0, 5, 1'b0);
`ifdef SOBOL_DIGITAL_SHIFT_EN
    seed_m = 16'h8000;
    run("shift_seed", 32'd1, 0, -1, 1'b0, 16'h0, 1, 1'b0);
    seed_m = '0;
`endif

    // Clamp: full period of 2^16-1 distinct nonzero points.
    run("full", 32'hFFFF_FFFF, 0, -1, 1'b0, 16'h0, 65535, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobol_point_gen.md
Name: sobol_point_gen

Overview:
- Single-dimension Sobol point generator using Gray-code (Antonov-Saleev) ordering.
- Emits u in Q(WIDTH-QFRAC).QFRAC, strictly in (0,1), one point per ready/valid handshake.
- Sits directly upstream of the inverse-CDF folding stage (u -> x in (0,0.5], negate flag). It feeds that stage's valid_in/u and takes its ready_out.
- The point at index 0 (u = 0) is never emitted, so the downstream stage never sees x = 0.

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH (32): output word width.
- QFRAC, fpga_cfg_pkg::FP_QFRAC (16): fraction bits. Also the direction-number width and the table depth.
- CNT_W, 32: width of the point counter and of n_points.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; begins a run. Sampled only in IDLE.
- n_points  in  CNT_W  number of points to emit. Sampled with start.
- dir_we  in  1  direction-number write strobe. Accepted only in IDLE.
- dir_addr  in  $clog2(QFRAC)  direction-number index k.
- dir_data  in  QFRAC  direction number v[k], as a Q0.QFRAC fraction.
- valid_out  out  1  u is valid.
- ready_in  in  1  downstream ready.
- u  out  WIDTH  point value; upper WIDTH-QFRAC bits are zero.
- index  out  CNT_W  Sobol index n of the current u (first point is n = 1).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset values:
  - Outputs: valid_out=0, u=0, index=0, busy=0, done=0.
  - FSM: IDLE.
  - Direction table: van der Corput, v[k] = 1 << (QFRAC-1-k).
- Reset is honoured mid-run: the run aborts and any dir_we writes are lost.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1, n_eff != 0:
  - Load count from n_eff; set n=1, x=v[0].
  - Next cycle: state RUN, valid_out=1, u=zero-extend(x), index=1. Latency from start to first valid is one cycle.
- IDLE, start=1, n_eff == 0: go to FIN with no valid_out.
- Clamp rule: n_eff = min(n_points, 2^QFRAC - 1). Beyond that index the Gray step would need v[QFRAC], which does not exist.
- RUN handshake (valid_out && ready_in):
  - Not the last point: x <= x ^ v[ctz(n+1)], n <= n+1, valid_out stays 1. Sustains one point per cycle while ready_in=1.
  - Last point (n == n_eff): valid_out <= 0, go to FIN.
- RUN with valid_out && !ready_in: u, index and valid_out are held stable, which is AXI-style.
- FIN: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. start and dir_we in the same IDLE cycle: the write lands, and the run uses the old v[0].
- dir_we outside IDLE is ignored; the table is never modified mid-run.
- ctz is the count of trailing zeros of n+1. It is always < QFRAC because of the clamp.

Optional Feature:
- Macro: SOBOL_DIGITAL_SHIFT_EN.
- Defined:
  - Adds input port shift_seed [QFRAC-1:0], latched on an accepted start.
  - Output u = zero-extend(x ^ seed_reg).
  - If the shifted value is 0, u = 1 LSB, so the strictly-positive output guarantee is kept.
- Undefined: no port is added, u = zero-extend(x), and the output logic is identical to the unshifted path.

Decomposition:
- fpga_cfg_pkg gains:
  - SOBOL_DIR_DEPTH = FP_QFRAC.
  - typedef sobol_dir_t (logic [FP_QFRAC-1:0]).
  - typedef sobol_state_e {IDLE, RUN, FIN}.
- Sub-module sobol_ctz: parameterised trailing-zero priority encoder, CNT_W in, $clog2(QFRAC) out, purely combinational.

Test Plan:
- Default table, start with n_points=4, ready_in=1: u = 0x8000, 0xC000, 0x4000, 0x6000 on consecutive cycles; index 1..4; done pulses one cycle after the 4th handshake.
- Same run with ready_in toggling 1,0,0,1,...: u and index are held stable while ready_in=0; no point is dropped or duplicated.
- n_points=0: no valid_out; done is asserted one cycle after start, then IDLE.
- n_points=0xFFFF_FFFF, QFRAC=16: exactly 65535 points; all u distinct and nonzero; done after the last handshake.
- Write v[0]=0x8000, v[1]=0xC000 in IDLE, then run 3 points: u = 0x8000, 0x4000, 0xC000. A dir_we issued during RUN has no effect.
- Assert rst_n=0 mid-run: the next cycle shows valid_out=0, busy=0, and the default table is restored. With SOBOL_DIGITAL_SHIFT_EN and seed 0x8000, the first point maps to u=0x0001.
